// File: rtl/alu_shift_pkg.sv
// Shared types and constants for the ARM-style shift/ALU datapath.
// Optional feature macro: ALU_SHIFT_RRX_EN (immediate ROR#0 performs RRX).
package alu_shift_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned AMT_W    = 8;
    localparam int unsigned SHOP_W   = 3;
    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } alu_op_e;

    // SHIFT_OP[2:1] selects the shift type; SHIFT_OP[0] selects register amount
    typedef enum logic [1:0] {
        SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11
    } shift_type_e;

    localparam int unsigned SHIFT_REG_BIT = 0;

    // Bit n set means opcode n is logical (C from shifter, V preserved)
    localparam logic [15:0] LOGICAL_OPS = 16'hF303;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    function automatic logic is_logical(input alu_op_e op);
        return LOGICAL_OPS[op];
    endfunction

endpackage

// File: rtl/alu_barrel_shifter.sv
// Combinational barrel shifter producing ALU operand B and the shifter carry.
// Optional feature macro: ALU_SHIFT_RRX_EN (immediate ROR#0 performs RRX).
module alu_barrel_shifter
    import alu_shift_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amount,
    input  logic [SHOP_W-1:0] op,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    logic              reg_src;
    shift_type_e       kind;
    logic [AMT_W-1:0]  amt;
    logic [4:0]        sh;
    logic [DATA_W:0]   lsl;
    logic [DATA_W:0]   lsr;
    logic [DATA_W:0]   asr;
    logic [DATA_W-1:0] rot;

    assign reg_src = op[SHIFT_REG_BIT];
    assign kind    = shift_type_e'(op[2:1]);
    assign amt     = reg_src ? amount : AMT_W'(amount[4:0]);
    assign sh      = amt[4:0];

    // Extra bit on each side captures the last bit shifted out
    assign lsl = {1'b0, data} << sh;
    assign lsr = {data, 1'b0} >> sh;
    assign asr = $signed({data, 1'b0}) >>> sh;
    assign rot = (data >> sh) | (data << (6'd32 - {1'b0, sh}));

    always_comb begin
        result    = data;
        carry_out = carry_in;
        if (amt == '0) begin
            if (!reg_src) begin
                case (kind)
                    SH_LSR: begin
                        result    = '0;
                        carry_out = data[31];
                    end
                    SH_ASR: begin
                        result    = {DATA_W{data[31]}};
                        carry_out = data[31];
                    end
                    SH_ROR: begin
`ifdef ALU_SHIFT_RRX_EN
                        result    = {carry_in, data[31:1]};
                        carry_out = data[0];
`endif
                    end
                    default: ;
                endcase
            end
        end else if (amt >= AMT_W'(DATA_W)) begin
            // Only reachable with a register-sourced amount
            case (kind)
                SH_LSL: begin
                    result    = '0;
                    carry_out = (amt == AMT_W'(DATA_W)) ? data[0] : 1'b0;
                end
                SH_LSR: begin
                    result    = '0;
                    carry_out = (amt == AMT_W'(DATA_W)) ? data[31] : 1'b0;
                end
                SH_ASR: begin
                    result    = {DATA_W{data[31]}};
                    carry_out = data[31];
                end
                default: begin
                    result    = rot;
                    carry_out = rot[31];
                end
            endcase
        end else begin
            case (kind)
                SH_LSL: begin
                    result    = lsl[DATA_W-1:0];
                    carry_out = lsl[DATA_W];
                end
                SH_LSR: begin
                    result    = lsr[DATA_W:1];
                    carry_out = lsr[0];
                end
                SH_ASR: begin
                    result    = asr[DATA_W:1];
                    carry_out = asr[0];
                end
                default: begin
                    result    = rot;
                    carry_out = rot[31];
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_shift_unit.sv
// Execute-stage shifter + 16-op ALU with the NZCV flag register.
// Optional feature macro: ALU_SHIFT_RRX_EN (immediate ROR#0 performs RRX).
module alu_shift_unit
    import alu_shift_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                S,
    input  logic [DATA_W-1:0]   Shift_Data,
    input  logic [AMT_W-1:0]    Shift_Num,
    input  logic [SHOP_W-1:0]   SHIFT_OP,
    input  logic [DATA_W-1:0]   A,
    input  logic [ALU_OP_W-1:0] ALU_OP,
    output logic [DATA_W-1:0]   F,
    output logic                N,
    output logic                Z,
    output logic                C,
    output logic                V
);

    logic [DATA_W-1:0] b;
    logic              sh_carry;
    alu_op_e           op;
    logic [DATA_W-1:0] add_x;
    logic [DATA_W-1:0] add_y;
    logic              add_cin;
    logic [DATA_W:0]   sum;
    logic              add_v;
    logic [DATA_W-1:0] logic_res;
    nzcv_t             flags_next;

    alu_barrel_shifter u_shifter (
        .data      (Shift_Data),
        .amount    (Shift_Num),
        .op        (SHIFT_OP),
        .carry_in  (C),
        .result    (b),
        .carry_out (sh_carry)
    );

    assign op = alu_op_e'(ALU_OP);

    // All arithmetic ops map onto one adder: x + y + cin, subtraction as x + ~y + 1
    always_comb begin
        add_x   = A;
        add_y   = b;
        add_cin = 1'b0;
        case (op)
            OP_SUB, OP_CMP: begin add_y = ~b; add_cin = 1'b1; end
            OP_RSB:         begin add_x = b; add_y = ~A; add_cin = 1'b1; end
            OP_ADC:         add_cin = C;
            OP_SBC:         begin add_y = ~b; add_cin = C; end
            OP_RSC:         begin add_x = b; add_y = ~A; add_cin = C; end
            default: ;
        endcase
        sum   = {1'b0, add_x} + {1'b0, add_y} + (DATA_W + 1)'(add_cin);
        add_v = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
    end

    always_comb begin
        logic_res = '0;
        case (op)
            OP_AND, OP_TST: logic_res = A & b;
            OP_EOR, OP_TEQ: logic_res = A ^ b;
            OP_ORR:         logic_res = A | b;
            OP_MOV:         logic_res = b;
            OP_BIC:         logic_res = A & ~b;
            OP_MVN:         logic_res = ~b;
            default: ;
        endcase
    end

    always_comb begin
        F            = is_logical(op) ? logic_res : sum[DATA_W-1:0];
        flags_next.n = F[31];
        flags_next.z = (F == '0);
        flags_next.c = is_logical(op) ? sh_carry : sum[DATA_W];
        flags_next.v = is_logical(op) ? V : add_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {N, Z, C, V} <= '0;
        end else if (S) begin
            {N, Z, C, V} <= flags_next;
        end
    end

endmodule

// File: tb/tb_alu_shift_unit.sv
// Self-checking bench for alu_shift_unit: arithmetic reference model plus directed literal checks.
module tb_alu_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        S = 1'b0;
    logic [31:0] Shift_Data = '0;
    logic [7:0]  Shift_Num = '0;
    logic [2:0]  SHIFT_OP = '0;
    logic [31:0] A = '0;
    logic [3:0]  ALU_OP = '0;
    wire  [31:0] F;
    wire         N, Z, C, V;

    int checks = 0;
    int failures = 0;

    logic [3:0]  mflags = '0;
    logic [35:0] mres;

    alu_shift_unit dut (
        .clk(clk), .rst_n(rst_n), .S(S), .Shift_Data(Shift_Data), .Shift_Num(Shift_Num),
        .SHIFT_OP(SHIFT_OP), .A(A), .ALU_OP(ALU_OP), .F(F), .N(N), .Z(Z), .C(C), .V(V)
    );

    always #5 clk = ~clk;

    // Reference: shift one bit at a time, then evaluate the op with wide signed/unsigned arithmetic
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] d, input logic [2:0] sop,
                                          input logic [7:0] num, input logic [3:0] fl);
        int          amt;
        int          kind;
        logic [31:0] b;
        logic [31:0] f;
        logic        sc, nc, nv;
        bit          is_sub;
        longint      ua, ub, sa, sb, ru, rs, cin;
        kind = int'(sop[2:1]);
        amt  = sop[0] ? int'(num) : int'(num[4:0]);
        b    = d;
        sc   = fl[1];
        if (!sop[0] && amt == 0) begin
            if (kind == 1 || kind == 2) amt = 32;
            else if (kind == 3) begin
`ifdef ALU_SHIFT_RRX_EN
                b  = {fl[1], d[31:1]};
                sc = d[0];
`endif
            end
        end
        for (int i = 0; i < amt; i++) begin
            case (kind)
                0:       begin sc = b[31]; b = b << 1; end
                1:       begin sc = b[0];  b = b >> 1; end
                2:       begin sc = b[0];  b = {b[31], b[31:1]}; end
                default: begin sc = b[0];  b = {b[0], b[31:1]}; end
            endcase
        end
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cin = fl[1] ? 64'sd1 : 64'sd0;
        nc = sc;
        nv = fl[0];
        ru = 0;
        rs = 0;
        is_sub = 1'b0;
        f = '0;
        case (op)
            4'h0, 4'h8: f = a & b;
            4'h1, 4'h9: f = a ^ b;
            4'hC:       f = a | b;
            4'hD:       f = b;
            4'hE:       f = a & ~b;
            4'hF:       f = ~b;
            default: begin
                case (op)
                    4'h2, 4'hA: begin ru = ua - ub; rs = sa - sb; is_sub = 1'b1; end
                    4'h3:       begin ru = ub - ua; rs = sb - sa; is_sub = 1'b1; end
                    4'h4, 4'hB: begin ru = ua + ub; rs = sa + sb; end
                    4'h5:       begin ru = ua + ub + cin; rs = sa + sb + cin; end
                    4'h6:       begin ru = ua - ub + cin - 1; rs = sa - sb + cin - 1; is_sub = 1'b1; end
                    default:    begin ru = ub - ua + cin - 1; rs = sb - sa + cin - 1; is_sub = 1'b1; end
                endcase
                f  = ru[31:0];
                nc = is_sub ? (ru >= 0) : (ru >= 64'sd4294967296);
                nv = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
            end
        endcase
        return {f, f[31], (f == 32'd0), nc, nv};
    endfunction

    assign mres = model(ALU_OP, A, Shift_Data, SHIFT_OP, Shift_Num, mflags);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mflags <= '0;
        else if (S) mflags <= mres[3:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("F_vs_model", F, mres[35:4]);
        check("NZCV_vs_model", 32'({N, Z, C, V}), 32'(mflags));
    end

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] sop, input logic [7:0] num, input logic s);
        @(posedge clk);
        #2;
        ALU_OP = op; A = a; Shift_Data = d; SHIFT_OP = sop; Shift_Num = num; S = s;
    endtask

    task automatic expect_vec(input string name, input logic [31:0] exp_f, input logic [3:0] exp_nzcv);
        @(negedge clk);
        #1;
        check({name, "_F"}, F, exp_f);
        @(posedge clk);
        #1;
        check({name, "_NZCV"}, 32'({N, Z, C, V}), 32'(exp_nzcv));
    endtask

    logic [3:0]  t_op  [8] = '{4'h1, 4'hC, 4'hE, 4'h7, 4'hB, 4'h9, 4'h6, 4'h8};
    logic [31:0] t_a   [8] = '{32'hF0F0F0F0, 32'h00000001, 32'hFFFFFFFF, 32'h00000001,
                               32'h80000000, 32'h12345678, 32'h80000000, 32'h000000FF};
    logic [31:0] t_d   [8] = '{32'h0FF00FF0, 32'h80000000, 32'h0000FFFF, 32'h00000010,
                               32'h80000000, 32'h12345678, 32'h00000001, 32'h0000000F};
    logic [2:0]  t_sop [8] = '{3'b000, 3'b010, 3'b101, 3'b110, 3'b001, 3'b001, 3'b000, 3'b111};
    logic [7:0]  t_num [8] = '{8'd4, 8'd0, 8'd8, 8'd8, 8'd0, 8'd33, 8'd0, 8'd32};

    initial begin
        #1 rst_n = 1'b0;
        #3;
        check("reset_nzcv", 32'({N, Z, C, V}), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        apply(4'h4, 32'h7FFFFFFF, 32'h1, 3'b000, 8'd0, 1'b1);
        expect_vec("add_ovf", 32'h80000000, 4'b1001);
        apply(4'h2, 32'd5, 32'd5, 3'b000, 8'd0, 1'b1);
        expect_vec("sub_eq", 32'h0, 4'b0110);
        apply(4'h2, 32'd5, 32'd3, 3'b000, 8'd0, 1'b0);
        expect_vec("sub_hold", 32'h2, 4'b0110);
        apply(4'hD, 32'h0, 32'h80000001, 3'b100, 8'd0, 1'b1);
        expect_vec("asr_imm0", 32'hFFFFFFFF, 4'b1010);
`ifdef ALU_SHIFT_RRX_EN
        apply(4'hD, 32'h0, 32'h00000002, 3'b110, 8'd0, 1'b1);
        expect_vec("rrx", 32'h80000001, 4'b1000);
`else
        apply(4'hD, 32'h0, 32'h00000002, 3'b110, 8'd0, 1'b1);
        expect_vec("ror_imm0_pass", 32'h00000002, 4'b0010);
`endif
        apply(4'hD, 32'h0, 32'h80000001, 3'b111, 8'd36, 1'b1);
        expect_vec("ror_reg36", 32'h18000000, 4'b0000);
        apply(4'h2, 32'd5, 32'd5, 3'b000, 8'd0, 1'b1);
        expect_vec("set_c", 32'h0, 4'b0110);
        apply(4'h5, 32'hFFFFFFFF, 32'h0, 3'b000, 8'd0, 1'b1);
        expect_vec("adc_wrap", 32'h0, 4'b0110);
        apply(4'h6, 32'h0, 32'h0, 3'b000, 8'd0, 1'b1);
        expect_vec("sbc_zero", 32'h0, 4'b0110);
        apply(4'hD, 32'h0, 32'h80000000, 3'b011, 8'd32, 1'b1);
        expect_vec("lsr_reg32", 32'h0, 4'b0110);
        apply(4'hD, 32'h0, 32'h80000000, 3'b011, 8'd40, 1'b1);
        expect_vec("lsr_reg40", 32'h0, 4'b0100);
        apply(4'h3, 32'd3, 32'd10, 3'b000, 8'd0, 1'b1);
        expect_vec("rsb", 32'd7, 4'b0010);
        apply(4'hF, 32'h0, 32'h0, 3'b000, 8'd0, 1'b1);
        expect_vec("mvn", 32'hFFFFFFFF, 4'b1010);

        // Mid-cycle reset: flags clear without a clock edge, F keeps tracking inputs
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_nzcv", 32'({N, Z, C, V}), 32'h0);
        check("async_rst_F", F, 32'hFFFFFFFF);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply(t_op[i], t_a[i], t_d[i], t_sop[i], t_num[i], 1'b1);
        end
        apply(4'hD, 32'h0, 32'h0, 3'b000, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
